adc_scan_scheduler: RTL and testbench

Sequencing controller for the ADC front end (real converter or the fake-data ADC model) in the ECU datapath. Generates periodic scan ticks, walks an enabled-channel mask, issues one TRIGGER per channel, waits for DVALID with a timeout, and hands each sample to the CPU-side consumer over a valid/ready interface. Sits between the ADC block and the result FIFO/MMIO register bank.

---
 rtl/adc_scan_scheduler_pkg.sv | 24 ++
 rtl/adc_scan_scheduler_period_timer.sv | 43 ++++
 rtl/adc_scan_scheduler.sv | 150 +++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_scan_scheduler_pkg.sv
// Shared definitions for the ADC scan scheduler: FSM encoding, width helper and
// the default channel-index width.
package adc_scan_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG    = 3'd1,
    ST_CONVERT = 3'd2,
    ST_PUSH    = 3'd3,
    ST_DONE    = 3'd4
  } scan_state_e;

  // Ceiling log2, never below 1 so a single-channel build still has an index bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_NUM_CHANNELS = 4;
  localparam int CH_IDX_W         = clog2_min1(DEF_NUM_CHANNELS);

endpackage

// File: rtl/adc_scan_scheduler_period_timer.sv
// Free-running scan period counter; emits a registered one-cycle tick on every
// wrap while enabled.
module scan_period_timer
  import adc_scan_scheduler_pkg::*;
#(
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_enable,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  output logic                    o_tick
);

  logic [PERIOD_WIDTH-1:0] r_cnt;
  logic                    r_tick;
  logic [PERIOD_WIDTH-1:0] w_last;
  logic                    w_wrap;

  // A period of 0 behaves as 1; >= keeps a shrunk period from running away.
  assign w_last = (i_period == '0) ? '0 : i_period - PERIOD_WIDTH'(1);
  assign w_wrap = (r_cnt >= w_last);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!i_enable) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + PERIOD_WIDTH'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/adc_scan_scheduler.sv
// ADC scan sequencer: on each period tick walks the latched channel mask,
// triggers one conversion per channel and hands samples out over valid/ready.
module adc_scan_scheduler
  import adc_scan_scheduler_pkg::*;
#(
  parameter int NUM_CHANNELS   = DEF_NUM_CHANNELS,
  parameter int WORD_SIZE      = 12,
  parameter int PERIOD_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES = 15,
  localparam int CH_W          = clog2_min1(NUM_CHANNELS)
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_enable,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  input  logic [NUM_CHANNELS-1:0] i_ch_mask,
  output logic                    o_adc_trigger,
  output logic [CH_W-1:0]         o_adc_channel,
  input  logic [WORD_SIZE-1:0]    i_adc_data,
  input  logic                    i_adc_dvalid,
  output logic [WORD_SIZE-1:0]    o_result_data,
  output logic [CH_W-1:0]         o_result_channel,
  output logic                    o_result_valid,
  input  logic                    i_result_ready,
  output logic                    o_scan_done,
  output logic                    o_overrun,
  output logic                    o_timeout_err,
  output logic                    o_busy
);

  localparam int TO_W = clog2_min1(TIMEOUT_CYCLES);

  scan_state_e             r_state, w_state_nxt;
  logic [NUM_CHANNELS-1:0] r_mask;
  logic [CH_W-1:0]         r_ch;
  logic [TO_W-1:0]         r_to_cnt;
  logic                    r_expired;
  logic [WORD_SIZE-1:0]    r_res_data;
  logic [CH_W-1:0]         r_res_ch;
  logic                    r_timeout_err;

  logic                    w_tick;
  logic [CH_W:0]           w_first;
  logic [CH_W:0]           w_next;
  logic                    w_capture;
  logic                    w_expire;
  logic                    w_advance;

  // Returns {found, index} of the lowest set mask bit at or above start.
  function automatic logic [CH_W:0] find_from(input logic [NUM_CHANNELS-1:0] mask,
                                              input int start);
    logic [CH_W:0] res;
    res = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= start)) res = {1'b1, CH_W'(i)};
    end
    return res;
  endfunction

  scan_period_timer #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_timer (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_enable (i_enable),
    .i_period (i_period),
    .o_tick   (w_tick)
  );

  assign w_first   = find_from(i_ch_mask, 0);
  assign w_next    = find_from(r_mask, int'(r_ch) + 1);
  assign w_capture = (r_state == ST_CONVERT) && !r_expired && i_adc_dvalid;
  assign w_expire  = (r_state == ST_CONVERT) && !r_expired && !i_adc_dvalid && (r_to_cnt == '0);
  // After an expiry CONVERT lingers one cycle so the error flag leads the next trigger.
  assign w_advance = ((r_state == ST_CONVERT) && r_expired) ||
                     ((r_state == ST_PUSH) && i_result_ready);

  // NOTE: defaults first so no path leaves a signal unassigned (no latches).
  always_comb begin
    w_state_nxt    = r_state;
    o_adc_trigger  = 1'b0;
    o_result_valid = 1'b0;
    o_scan_done    = 1'b0;
    unique case (r_state)
      ST_IDLE:    if (w_tick && w_first[CH_W]) w_state_nxt = ST_TRIG;
      ST_TRIG: begin
        o_adc_trigger = 1'b1;
        w_state_nxt   = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (w_capture)      w_state_nxt = ST_PUSH;
        else if (w_advance) w_state_nxt = w_next[CH_W] ? ST_TRIG : ST_DONE;
      end
      ST_PUSH: begin
        o_result_valid = 1'b1;
        if (w_advance) w_state_nxt = w_next[CH_W] ? ST_TRIG : ST_DONE;
      end
      ST_DONE: begin
        o_scan_done = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mask        <= '0;
      r_ch          <= '0;
      r_to_cnt      <= '0;
      r_expired     <= 1'b0;
      r_res_data    <= '0;
      r_res_ch      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && w_tick && w_first[CH_W]) begin
        r_mask <= i_ch_mask;
        r_ch   <= w_first[CH_W-1:0];
      end
      if (r_state == ST_TRIG) begin
        r_to_cnt  <= TO_W'(TIMEOUT_CYCLES - 1);
        r_expired <= 1'b0;
      end
      if (w_capture) begin
        r_res_data <= i_adc_data;
        r_res_ch   <= r_ch;
      end
      if (w_expire) begin
        r_timeout_err <= 1'b1;
        r_expired     <= 1'b1;
      end else if ((r_state == ST_CONVERT) && !r_expired && !i_adc_dvalid) begin
        r_to_cnt <= r_to_cnt - TO_W'(1);
      end
      if (w_advance && w_next[CH_W]) r_ch <= w_next[CH_W-1:0];
    end
  end

  assign o_adc_channel    = r_ch;
  assign o_result_data    = r_res_data;
  assign o_result_channel = r_res_ch;
  assign o_overrun        = w_tick && (r_state != ST_IDLE);
  assign o_timeout_err    = r_timeout_err;
  assign o_busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Bench for adc_scan_scheduler: ADC model feeding a result scoreboard, a table of
// scan configurations, and hand-written backpressure/timeout/reset sequences.
module tb_adc_scan_scheduler;
  import adc_scan_scheduler_pkg::*;

  logic                clk;
  logic                rst_n;
  logic                enable;
  logic [15:0]         period;
  logic [3:0]          ch_mask;
  logic                adc_trigger;
  logic [CH_IDX_W-1:0] adc_channel;
  logic [11:0]         adc_data;
  logic                adc_dvalid;
  logic [11:0]         result_data;
  logic [CH_IDX_W-1:0] result_channel;
  logic                result_valid;
  logic                result_ready;
  logic                scan_done;
  logic                overrun;
  logic                timeout_err;
  logic                busy;

  adc_scan_scheduler dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_enable        (enable),
    .i_period        (period),
    .i_ch_mask       (ch_mask),
    .o_adc_trigger   (adc_trigger),
    .o_adc_channel   (adc_channel),
    .i_adc_data      (adc_data),
    .i_adc_dvalid    (adc_dvalid),
    .o_result_data   (result_data),
    .o_result_channel(result_channel),
    .o_result_valid  (result_valid),
    .i_result_ready  (result_ready),
    .o_scan_done     (scan_done),
    .o_overrun       (overrun),
    .o_timeout_err   (timeout_err),
    .o_busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ADC model settings and scoreboard state.
  int                  dly     = 2;
  int                  drop_ch = 99;
  logic [13:0]         sb_q[$];
  logic [CH_IDX_W-1:0] trig_q[$];
  int n_trig = 0, n_res = 0, n_done = 0, n_ovr = 0, n_busy = 0;

  // ADC model: answers each trigger dly cycles later with a random sample.
  initial begin
    logic [CH_IDX_W-1:0] ch;
    logic [11:0]         data;
    logic                ok;
    adc_dvalid = 1'b0;
    adc_data   = '0;
    forever begin
      @(negedge clk);
      if (rst_n && adc_trigger && (int'(adc_channel) != drop_ch)) begin
        ch = adc_channel;
        ok = 1'b1;
        for (int k = 0; k < dly; k++) begin
          @(negedge clk);
          if (!rst_n) begin
            ok = 1'b0;
            break;
          end
        end
        if (ok) begin
          data       = 12'($urandom);
          adc_dvalid = 1'b1;
          adc_data   = data;
          sb_q.push_back({ch, data});
          @(negedge clk);
          adc_dvalid = 1'b0;
        end
      end
    end
  end

  // Monitor: sampled shortly after the falling edge, after all input updates.
  always @(negedge clk) begin
    logic [13:0] exp_res;
    #2;
    if (rst_n) begin
      if (adc_trigger) begin
        n_trig++;
        trig_q.push_back(adc_channel);
      end
      if (scan_done) n_done++;
      if (overrun)   n_ovr++;
      if (busy)      n_busy++;
      if (result_valid && result_ready) begin
        n_res++;
        check("sb_result_expected", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          exp_res = sb_q.pop_front();
          check("sb_result", {result_channel, result_data}, exp_res);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int       period;
    logic [3:0] mask;
    int       dly;
    int       n_scans;
    int       exp_trig;
    int       exp_res;
    int       exp_done;
    int       exp_ovr;
  } vec_t;

  vec_t vecs[6];

  task automatic do_reset();
    rst_n        = 1'b0;
    enable       = 1'b0;
    result_ready = 1'b1;
    drop_ch      = 99;
    repeat (3) @(negedge clk);
    sb_q.delete();
    trig_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int b_trig, b_res, b_done, b_ovr, b_busy, per, win, c;
    logic [CH_IDX_W-1:0] exp_ch[$];
    logic [11:0]         hold_data;
    logic [CH_IDX_W-1:0] hold_ch;

    vecs[0] = '{20, 4'b1011,  2,  3,  9,  9, 3, 0};
    vecs[1] = '{ 0, 4'b0000,  2, 10,  0,  0, 0, 0};
    vecs[2] = '{ 3, 4'b0001,  1,  4,  2,  2, 2, 2};
    vecs[3] = '{40, 4'b1111,  2,  2,  8,  8, 2, 0};
    vecs[4] = '{16, 4'b1000,  3,  3,  3,  3, 3, 0};
    vecs[5] = '{60, 4'b0110, 15,  1,  2,  2, 1, 0};

    rst_n        = 1'b0;
    enable       = 1'b0;
    period       = '0;
    ch_mask      = '0;
    result_ready = 1'b0;
    #12;
    check("rst_trigger", 32'(adc_trigger), 0);
    check("rst_channel", 32'(adc_channel), 0);
    check("rst_result_valid", 32'(result_valid), 0);
    check("rst_result_data", 32'(result_data), 0);
    check("rst_scan_done", 32'(scan_done), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_busy", 32'(busy), 0);

    // Table-driven scan configurations with READY tied high.
    foreach (vecs[v]) begin
      do_reset();
      period  = 16'(vecs[v].period);
      ch_mask = vecs[v].mask;
      dly     = vecs[v].dly;
      b_trig = n_trig; b_res = n_res; b_done = n_done; b_ovr = n_ovr; b_busy = n_busy;
      per = (vecs[v].period == 0) ? 1 : vecs[v].period;
      win = vecs[v].n_scans * per + per / 2;
      enable = 1'b1;
      repeat (win) @(negedge clk);
      enable = 1'b0;
      repeat (60) @(negedge clk);
      check($sformatf("v%0d_triggers", v), 32'(n_trig - b_trig), 32'(vecs[v].exp_trig));
      check($sformatf("v%0d_results", v), 32'(n_res - b_res), 32'(vecs[v].exp_res));
      check($sformatf("v%0d_scan_done", v), 32'(n_done - b_done), 32'(vecs[v].exp_done));
      check($sformatf("v%0d_overrun", v), 32'(n_ovr - b_ovr), 32'(vecs[v].exp_ovr));
      check($sformatf("v%0d_timeout_err", v), 32'(timeout_err), 0);
      check($sformatf("v%0d_sb_drained", v), 32'(sb_q.size()), 0);
      if (vecs[v].mask == 4'b0000) check($sformatf("v%0d_busy_cycles", v), 32'(n_busy - b_busy), 0);
      exp_ch.delete();
      for (int s = 0; s < vecs[v].exp_done; s++)
        for (int i = 0; i < 4; i++)
          if (vecs[v].mask[i]) exp_ch.push_back(CH_IDX_W'(i));
      check($sformatf("v%0d_trig_list_len", v), 32'(trig_q.size()), 32'(exp_ch.size()));
      for (int i = 0; i < trig_q.size() && i < exp_ch.size(); i++)
        check($sformatf("v%0d_trig_ch%0d", v, i), 32'(trig_q[i]), 32'(exp_ch[i]));
    end

    // Backpressure: result held while READY is low, next trigger right after accept.
    do_reset();
    period = 16'd12; ch_mask = 4'b0011; dly = 1; result_ready = 1'b0;
    enable = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!adc_trigger && c < 50);
    check("bp_tick_to_trigger_cycle", 32'(c), 32'd13);
    enable = 1'b0;
    check("bp_first_channel", 32'(adc_channel), 0);
    @(negedge clk);
    check("bp_valid_before_dvalid", 32'(result_valid), 0);
    @(negedge clk);
    check("bp_valid_after_dvalid", 32'(result_valid), 1);
    check("bp_result_channel", 32'(result_channel), 0);
    hold_data = result_data;
    hold_ch   = result_channel;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", k), 32'(result_valid), 1);
      check($sformatf("bp_hold_data%0d", k), 32'(result_data), 32'(hold_data));
      check($sformatf("bp_hold_ch%0d", k), 32'(result_channel), 32'(hold_ch));
      check($sformatf("bp_no_trigger%0d", k), 32'(adc_trigger), 0);
    end
    result_ready = 1'b1;
    @(negedge clk);
    check("bp_trigger_after_accept", 32'(adc_trigger), 1);
    check("bp_second_channel", 32'(adc_channel), 1);
    repeat (2) @(negedge clk);
    check("bp_second_valid", 32'(result_valid), 1);
    @(negedge clk);
    check("bp_scan_done_after_last", 32'(scan_done), 1);
    @(negedge clk);
    check("bp_idle_after_done", 32'(busy), 0);
    check("bp_sb_drained", 32'(sb_q.size()), 0);

    // Timeout on channel 1: no result, error after 16 cycles, channel 2 next.
    do_reset();
    period = 16'd200; ch_mask = 4'b0111; dly = 2; drop_ch = 1;
    b_res = n_res;
    enable = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!(adc_trigger && adc_channel == 1) && c < 400);
    check("to_ch1_triggered", 32'(adc_trigger && adc_channel == 1), 1);
    enable = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k <= 16) check($sformatf("to_hold_ch%0d", k), 32'(adc_channel), 1);
      if (k == 15) check("to_err_not_yet", 32'(timeout_err), 0);
      if (k == 16) begin
        check("to_err_set", 32'(timeout_err), 1);
        check("to_no_trigger_yet", 32'(adc_trigger), 0);
      end
      if (k == 17) begin
        check("to_next_trigger", 32'(adc_trigger), 1);
        check("to_next_channel", 32'(adc_channel), 2);
      end
    end
    repeat (20) @(negedge clk);
    check("to_err_sticky", 32'(timeout_err), 1);
    check("to_results", 32'(n_res - b_res), 2);
    check("to_sb_drained", 32'(sb_q.size()), 0);

    // Stray DVALID while idle, then reset in the middle of a conversion.
    adc_dvalid = 1'b1;
    adc_data   = 12'hABC;
    repeat (2) @(negedge clk);
    check("stray_dvalid_no_valid", 32'(result_valid), 0);
    check("stray_dvalid_idle", 32'(busy), 0);
    adc_dvalid = 1'b0;
    period = 16'd5; ch_mask = 4'b1100; dly = 10; drop_ch = 99;
    enable = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!adc_trigger && c < 50);
    check("rs_first_channel", 32'(adc_channel), 2);
    repeat (3) @(negedge clk);
    check("rs_busy_in_convert", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rs_trigger", 32'(adc_trigger), 0);
    check("rs_channel", 32'(adc_channel), 0);
    check("rs_result_valid", 32'(result_valid), 0);
    check("rs_result_data", 32'(result_data), 0);
    check("rs_result_channel", 32'(result_channel), 0);
    check("rs_scan_done", 32'(scan_done), 0);
    check("rs_overrun", 32'(overrun), 0);
    check("rs_timeout_err", 32'(timeout_err), 0);
    check("rs_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    dly = 2;
    rst_n = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!adc_trigger && c < 50);
    check("rs_restart_cycle", 32'(c), 32'd6);
    check("rs_restart_channel", 32'(adc_channel), 2);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    check("rs_sb_drained", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
